// File: rtl/led_fader_pkg.sv
// led_fader_pkg: default sizes and brightness ceiling shared by the LED trail fader
package led_fader_pkg;
  localparam int NUM_LEDS = 10;
  localparam int PWM_BITS = 8;
  localparam logic [PWM_BITS-1:0] B_MAX = {PWM_BITS{1'b1}};
endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-cycle pulse every DECAY_DIV clocks
module tick_gen
  import led_fader_pkg::*;
#(
  parameter int DECAY_DIV = 500000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  output logic tick
);
  localparam int CW = $clog2(DECAY_DIV);
  localparam logic [CW-1:0] LAST = CW'(DECAY_DIV - 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) r_cnt <= '0;
    else r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  assign tick = r_cnt == LAST;
endmodule

// File: rtl/led_trail_fader.sv
// led_trail_fader: scanner-position loads full brightness per LED, which then decays
// geometrically on slow ticks and drives LEDR through a free-running PWM compare.
module led_trail_fader
  import led_fader_pkg::*;
#(
  parameter int NUM_LEDS    = led_fader_pkg::NUM_LEDS,
  parameter int PWM_BITS    = led_fader_pkg::PWM_BITS,
  parameter int DECAY_DIV   = 500000,
  parameter int DECAY_SHIFT = 2
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_LEDS-1:0] pos_onehot,
  output logic [NUM_LEDS-1:0] LEDR
);
  localparam logic [PWM_BITS-1:0] W_MAX = '1;
  logic [NUM_LEDS-1:0]               r_sync1, r_sync2, w_led;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] r_b, w_b_nxt;
  logic [PWM_BITS-1:0]               r_pwm;
  logic                              w_tick;
  tick_gen #(.DECAY_DIV(DECAY_DIV)) u_tick (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .tick    (w_tick)
  );
  genvar i;
  generate
    for (i = 0; i < NUM_LEDS; i++) begin : g_led
      logic [PWM_BITS-1:0] w_shr, w_step, w_dec;
      assign w_shr  = r_b[i] >> DECAY_SHIFT;
      // small values still fade: step never drops below 1, result never below 0
      assign w_step = (w_shr == '0) ? PWM_BITS'(1) : w_shr;
      assign w_dec  = (r_b[i] > w_step) ? r_b[i] - w_step : '0;
      assign w_b_nxt[i] = r_sync2[i] ? W_MAX : w_tick ? w_dec : r_b[i];
      assign w_led[i]   = (r_b[i] == W_MAX) || (r_pwm < r_b[i]);
    end
  endgenerate
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_b     <= '0;
      r_pwm   <= '0;
      LEDR    <= '0;
    end else begin
      r_sync1 <= pos_onehot;
      r_sync2 <= r_sync1;
      r_b     <= w_b_nxt;
      r_pwm   <= r_pwm + 1'b1;
      LEDR    <= w_led;
    end
endmodule

// File: tb/tb_led_trail_fader.sv
// tb_led_trail_fader: directed checks of reset, load/decay, PWM duty, collision, sweep, mid-fade reset
module tb_led_trail_fader;
  localparam int N = 10;
  typedef struct {
    logic [7:0] b;
    int         hi;
  } pwm_vec_t;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       pos = '0;
  logic [N-1:0]       ledr;
  logic [N-1:0][7:0]  fb, prev;
  int checks = 0, passes = 0;
  led_trail_fader #(.NUM_LEDS(N), .PWM_BITS(8), .DECAY_DIV(4), .DECAY_SHIFT(2)) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .pos_onehot(pos),
    .LEDR      (ledr)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    pos = '0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    pwm_vec_t pv [N];
    int       hi [N];
    int       decay_seq [21];
    int       idx, since, wraps, bad, p, j, k;
    decay_seq = '{255, 192, 144, 108, 81, 61, 46, 35, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};
    pv = '{'{8'd0, 0}, '{8'd1, 1}, '{8'd2, 2}, '{8'd64, 64}, '{8'd127, 127},
           '{8'd128, 128}, '{8'd200, 200}, '{8'd254, 254}, '{8'd255, 256}, '{8'd63, 63}};
    // reset holds everything at zero even with every position asserted
    pos = '1;
    rst_n = 1'b0;
    cyc(3);
    check("rst_ledr", ledr, 0);
    check("rst_b_any", |dut.r_b, 0);
    rst_n = 1'b1;
    cyc(3);
    check("rel_b_all_max", &dut.r_b, 1);
    check("rel_ledr_latency", ledr, 0);
    cyc(1);
    check("rel_ledr_all", ledr, 10'h3FF);
    // single load then decay sequence, one step every 4 cycles
    do_reset();
    pos = 10'h001;
    cyc(2);
    pos = '0;
    for (int t = 0; t < 20 && dut.r_b[0] != 8'd255; t++) cyc(1);
    check("load_b0", dut.r_b[0], 255);
    idx = 0;
    since = 0;
    for (int t = 0; t < 150 && idx < 20; t++) begin
      cyc(1);
      since++;
      if (int'(dut.r_b[0]) != decay_seq[idx]) begin
        idx++;
        check($sformatf("decay_step_%0d", idx), dut.r_b[0], decay_seq[idx]);
        if (idx > 1) check($sformatf("decay_interval_%0d", idx), since, 4);
        since = 0;
      end
    end
    check("decay_steps_seen", idx, 20);
    cyc(20);
    check("decay_hold_zero", dut.r_b[0], 0);
    // PWM duty with brightness pinned
    do_reset();
    for (int i = 0; i < N; i++) fb[i] = pv[i].b;
    force dut.r_b = fb;
    cyc(3);
    for (int i = 0; i < N; i++) hi[i] = 0;
    repeat (256) begin
      cyc(1);
      for (int i = 0; i < N; i++) hi[i] += int'(ledr[i]);
    end
    for (int i = 0; i < N; i++) check($sformatf("pwm_duty_led%0d_b%0d", i, pv[i].b), hi[i], pv[i].hi);
    release dut.r_b;
    // load of LED 5 lands on the same edge as a decay tick
    do_reset();
    for (int t = 0; t < 10 && !dut.w_tick; t++) cyc(1);
    check("coll_tick_align", dut.w_tick, 1);
    cyc(2);
    pos[5] = 1'b1;
    cyc(1);
    pos[5] = 1'b0;
    cyc(1);
    check("coll_pre_b5", dut.r_b[5], 0);
    check("coll_tick_next", dut.w_tick, 1);
    cyc(1);
    check("coll_load_wins", dut.r_b[5], 255);
    cyc(4);
    check("coll_then_decay", dut.r_b[5], 192);
    // scanner sweep 0..9..0, eight cycles per position
    do_reset();
    wraps = 0;
    prev = dut.r_b;
    for (int s = 0; s < 19; s++) begin
      p = (s < 10) ? s : 18 - s;
      pos = '0;
      pos[p] = 1'b1;
      repeat (8) begin
        cyc(1);
        for (int i = 0; i < N; i++)
          if (dut.r_b[i] > prev[i] && dut.r_b[i] != 8'd255) wraps++;
        prev = dut.r_b;
      end
      check($sformatf("sweep_cur_s%0d", s), dut.r_b[p], 255);
      if (s > 0) begin
        bad = 0;
        for (int d = 1; d < N; d++) begin
          j = (s < 10) ? p - d : p + d;
          k = (s < 10) ? j + 1 : j - 1;
          if (j >= 0 && j < N && !(dut.r_b[j] < dut.r_b[k] || (dut.r_b[j] == 0 && dut.r_b[k] == 0))) bad++;
        end
        check($sformatf("sweep_trail_s%0d", s), bad, 0);
      end
    end
    check("sweep_no_wrap", wraps, 0);
    // asynchronous reset in the middle of a fade
    do_reset();
    pos[2] = 1'b1;
    pos[7] = 1'b1;
    cyc(2);
    pos[2] = 1'b0;
    for (int t = 0; t < 40 && dut.r_b[2] != 8'd144; t++) cyc(1);
    check("mf_b2_144", dut.r_b[2], 144);
    check("mf_ledr7_pre", ledr[7], 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mf_ledr_async", ledr, 0);
    check("mf_b2_async", dut.r_b[2], 0);
    check("mf_sync2_async", dut.r_sync2, 0);
    pos = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      cyc(1);
      if (dut.r_b[2] != 8'd0) bad++;
    end
    check("mf_b2_stays_zero", bad, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
